// File: rtl/sample_capture_pkg.sv
// Shared types and constants for the sample capture block.
package sample_capture_pkg;

    localparam int MODE_W = 4;
    localparam logic [MODE_W-1:0] MODE_MAX = 4'd4;
    localparam int SAMPLE_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [MODE_W-1:0]   mode;
        logic [SAMPLE_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/sc_fifo.sv
// Show-ahead synchronous FIFO with single-cycle flush; head word is read combinationally.
module sc_fifo #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // When full, the slot being written is the head leaving this cycle.
    assign do_push = push && !flush && (!full || (pop && !empty));
    assign do_pop  = pop && !flush && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sample_capture.sv
// Captures strobed DDS samples tagged with the rate mode and drains them over valid/ready.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | sampling controller not settled; no capture
//   ST_RUN   | capture on each Enable strobe whose Mode matches Mode_q
//   ST_FLUSH | one cycle: discard FIFO, clear Overflow, latch new Mode
module sample_capture
    import sample_capture_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              Fg_CLK,
    input  logic              RESETn,
    input  logic              Ready,
    input  logic              Enable,
    input  logic [MODE_W-1:0] Mode,
    input  logic [DATA_W-1:0] Sample_in,
    output logic [DATA_W-1:0] Out_data,
    output logic [MODE_W-1:0] Out_mode,
    output logic              Out_valid,
    input  logic              Out_ready,
    output logic              Overflow,
    output logic [ADDR_W:0]   Count
);

    localparam int ENTRY_W = MODE_W + DATA_W;

    state_t              state;
    state_t              state_nxt;
    logic [MODE_W-1:0]   mode_q;
    logic                flush;
    logic                push_req;
    logic                pop;
    logic                full;
    logic                empty;
    logic [ENTRY_W-1:0]  wdata;
    logic [ENTRY_W-1:0]  rdata;

    always_ff @(posedge Fg_CLK) begin
        if (!RESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        flush     = 1'b0;
        push_req  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Ready) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // A strobe arriving with a new Mode belongs to the next rate; drop it quietly.
                push_req = Enable && (Mode == mode_q);
                if (!Ready || (Mode != mode_q)) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush     = 1'b1;
                state_nxt = Ready ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Fg_CLK) begin
        if (!RESETn || flush) begin
            mode_q <= Mode;
        end
    end

    always_ff @(posedge Fg_CLK) begin
        if (!RESETn || flush) begin
            Overflow <= 1'b0;
        end else if (push_req && full && !pop) begin
            Overflow <= 1'b1;
        end
    end

    assign pop       = Out_valid && Out_ready;
    assign Out_valid = !empty;
    assign wdata     = {mode_q, Sample_in};
    assign Out_mode  = rdata[ENTRY_W-1:DATA_W];
    assign Out_data  = rdata[DATA_W-1:0];

    sc_fifo #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (Fg_CLK),
        .rst_n (RESETn),
        .flush (flush),
        .push  (push_req),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .count (Count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_sample_capture.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_sample_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ready;
    logic        en;
    logic [3:0]  mode;
    logic [11:0] sample;
    logic [11:0] out_data;
    logic [3:0]  out_mode;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    // reference model: FIFO contents as a queue of {mode, data}
    logic [15:0] mq[$];
    int          m_phase;   // 0 idle, 1 capturing, 2 discarding
    logic        m_ovf;
    logic [3:0]  m_mode;

    sample_capture dut (
        .Fg_CLK    (clk),
        .RESETn    (rst_n),
        .Ready     (ready),
        .Enable    (en),
        .Mode      (mode),
        .Sample_in (sample),
        .Out_data  (out_data),
        .Out_mode  (out_mode),
        .Out_valid (out_valid),
        .Out_ready (out_ready),
        .Overflow  (overflow),
        .Count     (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_phase = 0;
            m_ovf   = 1'b0;
            m_mode  = mode;
        end else if (m_phase == 0) begin
            if (ready) m_phase = 1;
        end else if (m_phase == 1) begin
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (en && mode == m_mode) begin
                if (mq.size() < 16) mq.push_back({m_mode, sample});
                else m_ovf = 1'b1;
            end
            if (!ready || mode != m_mode) m_phase = 2;
        end else begin
            mq.delete();
            m_ovf   = 1'b0;
            m_mode  = mode;
            m_phase = ready ? 1 : 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("model_count", int'(count), mq.size());
            chk("model_valid", int'(out_valid), int'(mq.size() != 0));
            chk("model_ovf", int'(overflow), int'(m_ovf));
            if (mq.size() != 0) begin
                chk("model_data", int'(out_data), int'(mq[0][11:0]));
                chk("model_mode", int'(out_mode), int'(mq[0][15:12]));
            end
        end
    end

    // inputs applied at a falling edge; returns at the next falling edge
    task automatic step(input logic r, input logic e, input logic [3:0] m,
                        input logic [11:0] s, input logic o);
        ready = r; en = e; mode = m; sample = s; out_ready = o;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; ready = 1'b0; en = 1'b0; mode = 4'd0; sample = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        run_cmp = 1'b1;
        chk("rst_count", int'(count), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_ovf", int'(overflow), 0);

        // 1: no capture before Ready
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd0, 12'h3A0 + 12'(i), 1'b0);
        chk("idle_count", int'(count), 0);
        chk("idle_valid", int'(out_valid), 0);
        step(1'b1, 1'b0, 4'd0, 12'h0, 1'b0);

        // 2: streaming with downstream always ready
        step(1'b1, 1'b1, 4'd0, 12'h001, 1'b1);
        chk("t2_d1", int'(out_data), 'h001);
        chk("t2_m1", int'(out_mode), 0);
        step(1'b1, 1'b1, 4'd0, 12'h002, 1'b1);
        chk("t2_d2", int'(out_data), 'h002);
        step(1'b1, 1'b1, 4'd0, 12'h003, 1'b1);
        chk("t2_d3", int'(out_data), 'h003);
        chk("t2_cnt", int'(count), 1);
        step(1'b1, 1'b0, 4'd0, 12'h0, 1'b1);
        chk("t2_empty", int'(out_valid), 0);
        step(1'b1, 1'b0, 4'd0, 12'h0, 1'b1);
        chk("t2_no_underflow", int'(count), 0);

        // 3: overfill
        for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 4'd0, 12'(i), 1'b0);
        chk("t3_full", int'(count), 16);
        chk("t3_ovf", int'(overflow), 1);
        step(1'b1, 1'b0, 4'd0, 12'h0, 1'b0);
        chk("t3_hold", int'(out_data), 0);
        for (int i = 0; i < 16; i++) begin
            chk("t3_drain", int'(out_data), i);
            step(1'b1, 1'b0, 4'd0, 12'h0, 1'b1);
        end
        chk("t3_drained", int'(out_valid), 0);

        // mode change clears Overflow
        step(1'b1, 1'b0, 4'd1, 12'h0, 1'b0);
        step(1'b1, 1'b0, 4'd1, 12'h0, 1'b0);
        chk("flush_ovf", int'(overflow), 0);

        // 4: full FIFO with simultaneous pop and strobe
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 4'd1, 12'h100 + 12'(i), 1'b0);
        chk("t4_full", int'(count), 16);
        step(1'b1, 1'b1, 4'd1, 12'hABC, 1'b1);
        chk("t4_count", int'(count), 16);
        chk("t4_ovf", int'(overflow), 0);
        for (int i = 0; i < 15; i++) begin
            chk("t4_drain", int'(out_data), 'h101 + i);
            step(1'b1, 1'b0, 4'd1, 12'h0, 1'b1);
        end
        chk("t4_last", int'(out_data), 'hABC);
        chk("t4_last_mode", int'(out_mode), 1);
        step(1'b1, 1'b0, 4'd1, 12'h0, 1'b1);
        chk("t4_empty", int'(out_valid), 0);

        // 5: mode change with coincident strobe
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'd1, 12'h021 + 12'(i), 1'b0);
        chk("t5_three", int'(count), 3);
        step(1'b1, 1'b1, 4'd2, 12'h055, 1'b0);
        chk("t5_dropped", int'(count), 3);
        step(1'b1, 1'b0, 4'd2, 12'h0, 1'b0);
        chk("t5_flush_cnt", int'(count), 0);
        chk("t5_flush_ovf", int'(overflow), 0);
        step(1'b1, 1'b1, 4'd2, 12'h077, 1'b0);
        chk("t5_new_data", int'(out_data), 'h077);
        chk("t5_new_mode", int'(out_mode), 2);

        // 6: Ready drop then reset mid-stream
        step(1'b1, 1'b0, 4'd2, 12'h0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'd2, 12'h200 + 12'(i), 1'b0);
        chk("t6_five", int'(count), 5);
        step(1'b0, 1'b0, 4'd2, 12'h0, 1'b0);
        step(1'b0, 1'b1, 4'd2, 12'h0, 1'b0);
        chk("t6_flushed", int'(count), 0);
        step(1'b0, 1'b1, 4'd2, 12'h2FF, 1'b0);
        chk("t6_idle", int'(count), 0);
        step(1'b1, 1'b0, 4'd2, 12'h0, 1'b0);
        for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 4'd2, 12'h300 + 12'(i), 1'b0);
        chk("t6_ovf_set", int'(overflow), 1);
        rst_n = 1'b0;
        step(1'b1, 1'b0, 4'd3, 12'h0, 1'b0);
        chk("t6_rst_cnt", int'(count), 0);
        chk("t6_rst_valid", int'(out_valid), 0);
        chk("t6_rst_ovf", int'(overflow), 0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 4'd3, 12'h0, 1'b0);
        step(1'b1, 1'b1, 4'd3, 12'h456, 1'b0);
        chk("t6_rst_mode", int'(out_mode), 3);
        chk("t6_rst_data", int'(out_data), 'h456);
        step(1'b1, 1'b0, 4'd3, 12'h0, 1'b1);
        step(1'b1, 1'b0, 4'd3, 12'h0, 1'b1);

        run_cmp = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_capture.md
Name: sample_capture

Overview:
Consumer end of the sampling strobe interface. Each time the sampling controller asserts its Enable strobe, the block captures one DDS sample and tags it with the current Mode. It buffers the tagged samples in a small show-ahead FIFO and drains them downstream over a valid/ready handshake. A Mode change flushes the stale data, so the downstream reader never mixes sample rates.

Parameters:
DATA_W, 12, width of the DDS sample word
DEPTH, 16, FIFO entries; must be a power of 2
ADDR_W, 4, log2(DEPTH)

Ports:
Fg_CLK  in  1  system clock; all logic is on the rising edge
RESETn  in  1  synchronous reset, active-low
Ready  in  1  level; high once the sampling controller has settled
Enable  in  1  one-cycle sampling strobe
Mode  in  4  current rate mode, 0-4; sampling period is 10^Mode cycles
Sample_in  in  DATA_W  DDS sample, valid every cycle
Out_data  out  DATA_W  sample at the FIFO head
Out_mode  out  4  Mode tag of the head sample
Out_valid  out  1  head entry is present
Out_ready  in  1  downstream accepts the head entry
Overflow  out  1  sticky; a strobe was dropped because the FIFO was full
Count  out  ADDR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset: RESETn low at a clock edge sets the following.
  - state=IDLE, pointers=0, Count=0.
  - Out_valid=0, Overflow=0.
  - Mode_q=Mode.
  - Out_data and Out_mode are don't-care while Out_valid=0.
- State machine: IDLE, RUN, FLUSH.
  - IDLE: no capture. Go to RUN on the first cycle that Ready=1.
  - RUN: capture is enabled. If Ready=0, go to FLUSH. If Mode!=Mode_q, go to FLUSH.
  - FLUSH (exactly 1 cycle): pointers=0, Count=0, Overflow=0, Mode_q<=Mode. Next state is RUN if Ready=1, otherwise IDLE.
- Mode_q updates only in FLUSH and at reset.
- Push:
  - Condition: state==RUN && Enable && Mode==Mode_q.
  - Writes {Mode_q, Sample_in} at wr_ptr.
  - Entry appears at the head on the next cycle, i.e. 1-cycle latency from strobe to Out_valid.
- Pop: Out_valid && Out_ready advances rd_ptr.
- Show-ahead FIFO:
  - Out_valid = (Count != 0).
  - Out_data and Out_mode read mem[rd_ptr] combinationally.
  - Out_data and Out_mode must hold stable while Out_valid=1 && Out_ready=0.
- Pointer arithmetic:
  - ADDR_W-bit pointers that wrap naturally from DEPTH-1 to 0.
  - Count is ADDR_W+1 bits; +1 on push only, -1 on pop only, unchanged on both.
- Full (Count==DEPTH):
  - A push is accepted only if a pop occurs in the same cycle.
  - Otherwise the sample is dropped and Overflow<=1, which holds until FLUSH or reset.
- Empty (Count==0): Out_ready is ignored and Count never underflows.
- Strobe coinciding with a Mode change: the sample is dropped without setting Overflow; FLUSH follows.
- Pop during the cycle before FLUSH is honoured, but FLUSH discards all remaining entries anyway.
- Reset mid-operation: all FIFO contents are discarded. Mem contents need no reset.

Decomposition:
- Package sample_capture_pkg holds:
  - state encoding IDLE/RUN/FLUSH;
  - MODE_W=4 and MODE_MAX=4;
  - the entry struct {mode, data}.
- One natural sub-module, sc_fifo: a show-ahead synchronous FIFO with flush input, push/pop, count and full/empty.
- The FSM and capture gating stay in sample_capture.

Test Plan:
1. Reset, Ready=0, Enable pulses -> Count stays 0 and Out_valid=0. Raise Ready -> state RUN after 1 cycle.
2. RUN, Mode=0, Enable every cycle, Sample_in=0x001,0x002,0x003, Out_ready=1 -> Out_data sequence 0x001,0x002,0x003, each valid 1 cycle after its strobe, with Out_mode=0.
3. Out_ready=0, 17 strobes with Sample_in=0..16 -> Count=16 and Overflow=1. Drain -> Out_data 0..15, sample 16 absent.
4. Full FIFO with a simultaneous pop and strobe of 0xABC -> Count stays 16, Overflow stays 0, and 0xABC appears as the 16th entry after draining.
5. Three entries buffered, then Mode 1->2 with a coincident strobe -> FLUSH for 1 cycle: Count=0, Overflow=0, strobe dropped. The next strobe's entry has Out_mode=2.
6. Drop Ready while 5 entries are buffered -> FLUSH then IDLE, Count=0. Assert RESETn=0 mid-stream -> all outputs at reset values on the next edge.
